npu_output_interface: RTL and testbench
=======================================

NPU_OUTPUT_INTERFACE -- requirements
Module: npu_output_interface

Interface
REQ-001 SHALL have parameter DEPTH, default 16, output FIFO depth in 32-bit words (power of two).
REQ-002 SHALL have parameter ADDR_W, default 4, log2(DEPTH).
REQ-003 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port npu_output_interface_din  input  16  result word from sigmoid stage.
REQ-006 SHALL have port npu_output_interface_din_en  input  1  result strobe from scheduler (output FIFO write enable).
REQ-007 SHALL have port npu_output_interface_conf_data  input  16  output format config word.
REQ-008 SHALL have port npu_output_interface_conf_data_en  input  1  format register write enable.
REQ-009 SHALL have port npu_output_flush  input  1  end of invocation; emit any pending half-word.
REQ-010 SHALL have port npu_output_fifo_read_en  input  1  host pop.
REQ-011 SHALL have port npu_output_data  output  32  FIFO head word (first-word-fall-through).
REQ-012 SHALL have port npu_output_fifo_empty  output  1  FIFO holds 0 words.
REQ-013 SHALL have port npu_output_fifo_full  output  1  FIFO holds DEPTH words.
REQ-014 SHALL have port npu_output_overflow  output  1  sticky: a push was dropped.

Function
REQ-015 Format register: bit0 PACK (0 = one result per word, 1 = two per word); bit1 ZEXT (0 = sign-extend, 1 = zero-extend, unpacked mode only); bits15:2 ignored.
REQ-016 Format write SHALL take effect the cycle after conf_data_en; a same-cycle din uses the old format.
REQ-017 Unpacked: each din_en SHALL push {ext16(din), din} in that cycle; empty deasserts the next cycle.
REQ-018 Packer FSM states: HALF_EMPTY, HAVE_LOW.
REQ-019 Packed, HALF_EMPTY, din_en: latch din as low half -> HAVE_LOW; no push.
REQ-020 Packed, HAVE_LOW, din_en: push {din, low} -> HALF_EMPTY.
REQ-021 Flush in HAVE_LOW without din_en: push {16'h0000, low} -> HALF_EMPTY.
REQ-022 Flush with din_en in HAVE_LOW: din completes the word; flush adds no extra push.
REQ-023 Flush with din_en in HALF_EMPTY, packed: push {16'h0000, din}; stay HALF_EMPTY.
REQ-024 Flush in HALF_EMPTY with no din_en: no effect.
REQ-025 Format write in HAVE_LOW without din_en: pending half pushed zero-padded as in REQ-021.
REQ-026 At most one push per cycle.
REQ-027 Push while full with no pop: word dropped; pointers unchanged; overflow set.
REQ-028 Pop and push in the same cycle while full: both accepted; count unchanged.
REQ-029 Pop while empty: ignored, even if a push occurs that cycle.
REQ-030 Pointers SHALL wrap modulo DEPTH; occupancy counter ADDR_W+1 bits.
REQ-031 npu_output_data SHALL show the head word combinationally from storage; contents undefined when empty.

Reset
REQ-032 RST SHALL asynchronously clear pointers, counter, format register (0), low-half register, and overflow, and SHALL force FSM to HALF_EMPTY.
REQ-033 During/after reset: empty=1, full=0, overflow=0; a pending half-word is discarded.
REQ-034 FIFO storage array need not be reset.

Configuration
REQ-035 Macro NPU_OUTPUT_OVERFLOW_EN defined: overflow flag implemented per REQ-027, cleared only by RST.
REQ-036 Macro undefined: push-when-full is still dropped; npu_output_overflow tied to 0; no flag register.

Verification
REQ-037 Unpacked, ZEXT=0, din 16'h8001 -> next cycle empty=0, data=32'hFFFF8001; pop -> empty=1.
REQ-038 Unpacked, ZEXT=1, din 16'h8001 -> data=32'h00008001.
REQ-039 PACK=1, din 16'h1111 then 16'h2222 -> one word 32'h22221111; din 16'h3333 then flush -> 32'h00003333.
REQ-040 Unpacked, 17 pushes without pop -> full=1 after 16; 17th dropped; overflow=1 (macro on) or 0 (macro off); 16 pops return words 1..16 in order.
REQ-041 Full, simultaneous pop+push of 16'h00AA -> full stays 1; the new word is read last.
REQ-042 PACK=1, one din 16'h5555, then RST -> empty=1, FSM HALF_EMPTY; next pair 16'h1 and 16'h2 -> 32'h00020001.

Source files
------------

// File: rtl/npu_output_interface.sv
// npu_output_interface
// Output stage of the NPU. Results from the sigmoid stage are formatted,
// optionally packed two per 32-bit word, and queued in a first-word-fall-through
// FIFO that the host drains.
//
// Build option: define NPU_OUTPUT_OVERFLOW_EN to implement the sticky
// npu_output_overflow flag. When the macro is undefined, a push into a full
// FIFO is still dropped, and npu_output_overflow is tied low.
module npu_output_interface #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] npu_output_interface_din,
   input  logic        npu_output_interface_din_en,
   input  logic [15:0] npu_output_interface_conf_data,
   input  logic        npu_output_interface_conf_data_en,
   input  logic        npu_output_flush,
   input  logic        npu_output_fifo_read_en,
   output logic [31:0] npu_output_data,
   output logic        npu_output_fifo_empty,
   output logic        npu_output_fifo_full,
   output logic        npu_output_overflow
);

   // Packer states
   localparam logic [0:0] HALF_EMPTY = 1'b0;
   localparam logic [0:0] HAVE_LOW   = 1'b1;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   // Format register: bit0 = PACK, bit1 = ZEXT
   logic [1:0]        fmt_q, fmt_d;
   logic [0:0]        state_q, state_d;
   logic [15:0]       low_q, low_d;

   // FIFO state
   logic [31:0]       mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;

   // Packer-to-FIFO handshake
   logic              push_req;
   logic [31:0]       push_word;
   logic              do_pop;
   logic              do_push;
   logic              fifo_empty;
   logic              fifo_full;

   logic              pack;
   logic              zext;
   logic              unused_conf;

   assign pack        = fmt_q[0];
   assign zext        = fmt_q[1];
   assign unused_conf = ^npu_output_interface_conf_data[15:2];

   // Packer: format the incoming result and decide whether a word is pushed
   // this cycle. A same-cycle format write is seen only from the next cycle.
   always_comb begin
      push_req  = 1'b0;
      push_word = '0;
      state_d   = state_q;
      low_d     = low_q;
      fmt_d     = fmt_q;

      if (npu_output_interface_conf_data_en) begin
         fmt_d = npu_output_interface_conf_data[1:0];
      end

      if (npu_output_interface_din_en) begin
         if (!pack) begin
            push_req  = 1'b1;
            push_word = {zext ? 16'h0000 : {16{npu_output_interface_din[15]}},
                         npu_output_interface_din};
         end else if (state_q == HAVE_LOW) begin
            // Incoming result completes the word; a concurrent flush adds nothing.
            push_req  = 1'b1;
            push_word = {npu_output_interface_din, low_q};
            state_d   = HALF_EMPTY;
         end else if (npu_output_flush) begin
            push_req  = 1'b1;
            push_word = {16'h0000, npu_output_interface_din};
         end else begin
            low_d   = npu_output_interface_din;
            state_d = HAVE_LOW;
         end
      end else if ((state_q == HAVE_LOW) &&
                   (npu_output_flush || npu_output_interface_conf_data_en)) begin
         // Flush or format change drains the pending half, zero-padded.
         push_req  = 1'b1;
         push_word = {16'h0000, low_q};
         state_d   = HALF_EMPTY;
      end
   end

   // Packer and format registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fmt_q   <= '0;
         state_q <= HALF_EMPTY;
         low_q   <= '0;
      end else begin
         fmt_q   <= fmt_d;
         state_q <= state_d;
         low_q   <= low_d;
      end
   end

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == DEPTH_C);

   // Pop only when data is present; push is accepted when there is room or
   // when a pop frees a slot in the same cycle.
   assign do_pop  = npu_output_fifo_read_en && !fifo_empty;
   assign do_push = push_req && (!fifo_full || do_pop);

   // FIFO pointer and occupancy next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (ADDR_W+1)'(1);
         2'b01:   count_d = count_q - (ADDR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO pointers and occupancy
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage write (storage is not reset)
   always_ff @(posedge CLK) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_word;
      end
   end

`ifdef NPU_OUTPUT_OVERFLOW_EN
   logic ovf_q;

   // Sticky overflow: set when a requested push is dropped, cleared only by reset
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ovf_q <= 1'b0;
      end else if (push_req && !do_push) begin
         ovf_q <= 1'b1;
      end
   end

   assign npu_output_overflow = ovf_q;
`else
   assign npu_output_overflow = 1'b0;
`endif

   assign npu_output_data       = mem_q[rd_ptr_q];
   assign npu_output_fifo_empty = fifo_empty;
   assign npu_output_fifo_full  = fifo_full;

endmodule

// File: tb/tb_npu_output_interface.sv
// Testbench for npu_output_interface: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_npu_output_interface;

   localparam int DEPTH = 16;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] din = '0;
   logic        din_en = 1'b0;
   logic [15:0] conf = '0;
   logic        conf_en = 1'b0;
   logic        flush = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] dout;
   logic        empty;
   logic        full;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] mq[$];
   bit          m_pend;
   logic [15:0] m_low;
   logic [1:0]  m_fmt;
   bit          m_ovf;

   npu_output_interface #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
      .CLK                               (CLK),
      .RST                               (RST),
      .npu_output_interface_din          (din),
      .npu_output_interface_din_en       (din_en),
      .npu_output_interface_conf_data    (conf),
      .npu_output_interface_conf_data_en (conf_en),
      .npu_output_flush                  (flush),
      .npu_output_fifo_read_en           (rd_en),
      .npu_output_data                   (dout),
      .npu_output_fifo_empty             (empty),
      .npu_output_fifo_full              (full),
      .npu_output_overflow               (ovf)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit exp_ovf();
`ifdef NPU_OUTPUT_OVERFLOW_EN
      return m_ovf;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".empty"}, {31'b0, empty}, {31'b0, mq.size() == 0});
      chk({tag, ".full"},  {31'b0, full},  {31'b0, mq.size() == DEPTH});
      chk({tag, ".ovf"},   {31'b0, ovf},   {31'b0, exp_ovf()});
      if (mq.size() > 0) chk({tag, ".data"}, dout, mq[0]);
   endtask

   // One clock cycle: drive inputs, advance the model, check after the edge.
   task automatic step(input bit den, input logic [15:0] d, input bit cen,
                       input logic [15:0] c, input bit fl, input bit pop,
                       input string tag);
      bit          have_word;
      logic [31:0] word;
      bit          can_pop;
      @(negedge CLK);
      din = d; din_en = den; conf = c; conf_en = cen; flush = fl; rd_en = pop;

      have_word = 1'b0;
      word      = '0;
      if (den) begin
         have_word = 1'b1;
         if (!m_fmt[0]) begin
            word = m_fmt[1] ? {16'h0000, d} : {{16{d[15]}}, d};
         end else if (m_pend) begin
            word   = {d, m_low};
            m_pend = 1'b0;
         end else if (fl) begin
            word = {16'h0000, d};
         end else begin
            have_word = 1'b0;
            m_pend    = 1'b1;
            m_low     = d;
         end
      end else if (m_pend && (fl || cen)) begin
         have_word = 1'b1;
         word      = {16'h0000, m_low};
         m_pend    = 1'b0;
      end
      can_pop = pop && (mq.size() > 0);
      if (have_word && !(mq.size() < DEPTH || can_pop)) begin
         m_ovf     = 1'b1;
         have_word = 1'b0;
      end
      if (can_pop) void'(mq.pop_front());
      if (have_word) mq.push_back(word);
      if (cen) m_fmt = c[1:0];

      @(posedge CLK);
      #1;
      check_outputs(tag);
   endtask

   task automatic idle(input string tag);
      step(0, '0, 0, '0, 0, 0, tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge CLK);
      din_en = 0; conf_en = 0; flush = 0; rd_en = 0;
      RST = 1'b1;
      #1;
      mq.delete();
      m_pend = 0; m_low = '0; m_fmt = '0; m_ovf = 0;
      check_outputs(tag);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   initial begin
      m_pend = 0; m_low = '0; m_fmt = '0; m_ovf = 0;
      #2;
      check_outputs("por");
      do_reset("rst0");

      // Unpacked sign-extend, then pop
      step(1, 16'h8001, 0, '0, 0, 0, "sext");
      chk("sext.val", dout, 32'hFFFF8001);
      step(0, '0, 0, '0, 0, 1, "sext.pop");
      chk("sext.empty", {31'b0, empty}, 32'd1);

      // Zero-extend: format write, same-cycle din still uses old format
      step(1, 16'h9000, 1, 16'hFFFE, 0, 0, "zext.same");
      chk("zext.old", dout, 32'hFFFF9000);
      step(1, 16'h8001, 0, '0, 0, 1, "zext");
      chk("zext.val", dout, 32'h00008001);
      step(0, '0, 0, '0, 0, 1, "zext.pop");

      // Packed pairs and flush
      step(0, '0, 1, 16'h0001, 0, 0, "pack.cfg");
      step(1, 16'h1111, 0, '0, 0, 0, "pack.lo");
      chk("pack.noword", {31'b0, empty}, 32'd1);
      step(1, 16'h2222, 0, '0, 0, 0, "pack.hi");
      chk("pack.val", dout, 32'h22221111);
      step(1, 16'h3333, 0, '0, 0, 1, "pack.lo2");
      step(0, '0, 0, '0, 1, 0, "pack.flush");
      chk("pack.flushval", dout, 32'h00003333);
      step(0, '0, 0, '0, 1, 1, "pack.flush_idle");
      step(1, 16'h4444, 0, '0, 1, 0, "pack.flush_din_he");
      step(1, 16'h5555, 0, '0, 0, 0, "pack.lo3");
      step(1, 16'h6666, 0, '0, 1, 0, "pack.flush_din_hl");
      step(1, 16'h7777, 0, '0, 0, 0, "pack.lo4");
      step(0, '0, 1, 16'h0000, 0, 0, "pack.cfg_drain");
      for (int i = 0; i < 4; i++) step(0, '0, 0, '0, 0, 1, "pack.drain");

      // Fill to full and beyond
      do_reset("rst1");
      for (int i = 1; i <= 17; i++) step(1, 16'(i), 0, '0, 0, 0, "fill");
      chk("fill.full", {31'b0, full}, 32'd1);
`ifdef NPU_OUTPUT_OVERFLOW_EN
      chk("fill.ovf", {31'b0, ovf}, 32'd1);
`else
      chk("fill.ovf", {31'b0, ovf}, 32'd0);
`endif
      for (int i = 1; i <= 16; i++) begin
         chk("fill.order", dout, 32'(i));
         step(0, '0, 0, '0, 0, 1, "fill.pop");
      end

      // Simultaneous pop and push while full
      do_reset("rst2");
      for (int i = 1; i <= 16; i++) step(1, 16'(i + 32), 0, '0, 0, 0, "full2");
      step(1, 16'h00AA, 0, '0, 0, 1, "full2.pp");
      chk("full2.still", {31'b0, full}, 32'd1);
      for (int i = 0; i < 15; i++) step(0, '0, 0, '0, 0, 1, "full2.pop");
      chk("full2.last", dout, 32'h000000AA);
      step(0, '0, 0, '0, 0, 1, "full2.popl");

      // Reset discards a pending half-word
      step(0, '0, 1, 16'h0001, 0, 0, "rst3.cfg");
      step(1, 16'h5555, 0, '0, 0, 0, "rst3.lo");
      do_reset("rst3");
      step(0, '0, 1, 16'h0001, 0, 0, "rst3.cfg2");
      step(1, 16'h0001, 0, '0, 0, 0, "rst3.lo2");
      step(1, 16'h0002, 0, '0, 0, 0, "rst3.hi2");
      chk("rst3.val", dout, 32'h00020001);

      // Random traffic in phases with different pop pressure
      do_reset("rst4");
      for (int i = 0; i < 3000; i++) begin
         int pop_pct;
         pop_pct = ((i / 300) % 3 == 0) ? 10 : ((i / 300) % 3 == 1) ? 45 : 85;
         step($urandom_range(99) < 60, 16'($urandom),
              $urandom_range(99) < 4, 16'($urandom),
              $urandom_range(99) < 10, $urandom_range(99) < pop_pct, "rand");
      end
      idle("end");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Guard against a stalled run
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, got no finish expected finish");
      $fatal(1);
   end

endmodule
